// File: rtl/ma_frame_ctrl.sv
// Frame controller: streams one frame of samples from RAM into a moving-average datapath
// and queues the averaged results in a small output FIFO.
// Results leave through a valid/ready stream; RAM reads stall while the FIFO plus reads in flight would overflow.

// Generic synchronous FIFO with valid/ready on both sides.
// Latency: one cycle from push to head; head data is combinational from storage.
// Backpressure: in_rdy drops when full; the head is held while out_rdy is low.
module ma_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [W-1:0]               in_dat,
    output logic                       in_rdy,
    output logic                       out_vld,
    output logic [W-1:0]               out_dat,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign in_rdy  = (cnt_q != CNT_W'(DEPTH));
    assign out_vld = (cnt_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = cnt_q;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_dat;
    end
endmodule

// Frame sequencer: IDLE -> CLEAR -> RUN -> DRAIN -> DONE, one RAM read per cycle while there is room.
// Latency: sample to datapath one cycle after its read, result pushed one cycle after that.
// Backpressure: reads stop while fifo_count + inflight reaches FIFO_DEPTH; the stream holds its head.
module ma_frame_ctrl #(
    parameter int FRAME_LEN  = 256,
    parameter int BURST_SIZE = 16,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic [ADDR_W-1:0] ibase,
    output logic              obusy,
    output logic              odone,
    output logic              oram_ren,
    output logic [ADDR_W-1:0] oram_addr,
    input  logic [15:0]       iram_rdata,
    output logic              oma_clr,
    output logic              oma_valid,
    output logic [15:0]       oma_data,
    output logic [31:0]       oma_idx,
    input  logic              ima_valid,
    input  logic [15:0]       ima_data,
    input  logic [31:0]       ima_idx,
    output logic              ovalid,
    output logic [15:0]       odata,
    output logic [31:0]       oidx,
    input  logic              iready
);
    localparam int OFF_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_LEN - 1);

    if (BURST_SIZE > FRAME_LEN || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_params
        $error("ma_frame_ctrl: FRAME_LEN must be a power of 2 no smaller than BURST_SIZE");
    end

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [OFF_W-1:0]  idx_q, idx_d;
    logic [1:0]        inflight_q, inflight_d;
    logic              mav_q, mav_d;
    logic              pend_q, pend_d;
    logic              obusy_q, obusy_d;
    logic              odone_q, odone_d;

    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_in_rdy;
    logic              fifo_push;
    logic [47:0]       fifo_head;
    logic              room;
    logic              issue;

    // Reads already issued will each land in the FIFO, so they are counted as occupied space.
    assign room  = (32'(fifo_cnt) + 32'(inflight_q)) < FIFO_DEPTH;
    assign issue = (state_q == S_RUN) && room && !irst;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        offset_d = offset_q;
        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    base_d   = ibase;
                    offset_d = '0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_RUN;
            S_RUN: begin
                if (issue) begin
                    offset_d = offset_q + 1'b1;
                    if (offset_q == LAST_OFF) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight_q == 2'd0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mav_d  = issue;
        pend_d = mav_q;
        idx_d  = issue ? offset_q : idx_q;
        case ({issue, pend_q})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        obusy_d = (state_d != S_IDLE);
        odone_d = (state_d == S_DONE);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            offset_q   <= '0;
            idx_q      <= '0;
            inflight_q <= '0;
            mav_q      <= 1'b0;
            pend_q     <= 1'b0;
            obusy_q    <= 1'b0;
            odone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            offset_q   <= offset_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            mav_q      <= mav_d;
            pend_q     <= pend_d;
            obusy_q    <= obusy_d;
            odone_q    <= odone_d;
        end
    end

    // The pipeline slot is released when pend_q retires, whether or not the datapath produced a result.
    assign fifo_push = pend_q && ima_valid && fifo_in_rdy;

    ma_fifo #(
        .W     (48),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iclk),
        .rst     (irst),
        .in_vld  (fifo_push),
        .in_dat  ({ima_data, ima_idx}),
        .in_rdy  (fifo_in_rdy),
        .out_vld (ovalid),
        .out_dat (fifo_head),
        .out_rdy (iready),
        .count   (fifo_cnt)
    );

    assign obusy     = obusy_q;
    assign odone     = odone_q;
    assign oram_ren  = issue;
    assign oram_addr = issue ? (base_q + ADDR_W'(offset_q)) : '0;
    assign oma_clr   = irst || (state_q == S_CLEAR);
    assign oma_valid = mav_q;
    assign oma_data  = mav_q ? iram_rdata : 16'd0;
    assign oma_idx   = 32'(idx_q);
    assign odata     = ovalid ? fifo_head[47:32] : 16'd0;
    assign oidx      = ovalid ? fifo_head[31:0]  : 32'd0;
endmodule

// File: doc/ma_frame_ctrl.md
MA_FRAME_CTRL -- requirements
Module: ma_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, samples per frame (power of 2, >= BURST_SIZE).
REQ-002 SHALL have parameter BURST_SIZE, default 16, window length of the attached moving-average datapath.
REQ-003 SHALL have parameter ADDR_W, default 10, sample RAM address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries.
REQ-005 SHALL use one clock and a synchronous, active-high reset:
- iclk  in  1  clock
- irst  in  1  synchronous active-high reset
REQ-006 SHALL have the following control ports:
- istart  in  1  frame start pulse
- ibase  in  ADDR_W  frame base address
- obusy  out  1  high outside IDLE
- odone  out  1  1-cycle frame-complete pulse
REQ-007 SHALL have the following sample RAM ports:
- oram_ren  out  1  read enable
- oram_addr  out  ADDR_W  read address
- iram_rdata  in  16  read data, valid one cycle after oram_ren
REQ-008 SHALL have the following datapath ports:
- oma_clr  out  1  active-high datapath clear
- oma_valid  out  1  sample strobe
- oma_data  out  16  sample
- oma_idx  out  32  sample index
- ima_valid  in  1  average valid
- ima_data  in  16  average
- ima_idx  in  32  index of oldest window sample
REQ-009 SHALL have the following result stream ports:
- ovalid  out  1  result valid
- odata  out  16  average
- oidx  out  32  index
- iready  in  1  consumer ready

Function
REQ-010 SHALL implement states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-011 In IDLE, istart=1 SHALL latch ibase, zero the offset counter, and enter CLEAR; istart in any other state SHALL be ignored.
REQ-012 CLEAR SHALL last exactly one cycle with oma_clr=1, then enter RUN.
REQ-013 In RUN, a read SHALL issue (oram_ren=1, oram_addr=(base+offset) mod 2^ADDR_W, offset++) only when fifo_count+inflight < FIFO_DEPTH; inflight = issued reads not yet pushed or discarded (max 2).
REQ-014 One cycle after each read, the block SHALL drive oma_valid=1, oma_data=iram_rdata, oma_idx=zero-extended offset of that read; oma_valid SHALL be 0 otherwise.
REQ-015 One cycle after each oma_valid, the block SHALL push {ima_data, ima_idx} into the FIFO if ima_valid=1, else discard it; the inflight slot SHALL be freed either way.
REQ-016 After the read with offset FRAME_LEN-1, the block SHALL enter DRAIN, issue no further reads, and stay in DRAIN until inflight=0.
REQ-017 From DRAIN, the block SHALL enter DONE, assert odone for one cycle, then return to IDLE; the FIFO SHALL continue to drain in IDLE.
REQ-018 Each frame SHALL yield exactly FRAME_LEN-BURST_SIZE+1 results.
REQ-019 The result stream SHALL be the FIFO head; transfer SHALL occur when ovalid&&iready; odata/oidx SHALL be held stable while ovalid&&!iready.
REQ-020 A simultaneous push and pop SHALL leave fifo_count unchanged; the FIFO SHALL never overflow.
REQ-021 obusy SHALL be 1 in CLEAR, RUN, DRAIN, and DONE.

Reset
REQ-022 While irst=1, the block SHALL force state IDLE, empty the FIFO, zero inflight and offset, and set oma_clr=1.
REQ-023 Reset values SHALL be: obusy=0, odone=0, oram_ren=0, oma_valid=0, ovalid=0; odata, oidx, oram_addr, oma_data, and oma_idx=0.
REQ-024 An irst pulse mid-frame SHALL abandon the frame with no odone, and SHALL lose any FIFO contents.

Verification
REQ-025 RAM all 100, ibase=0, iready=1, istart -> 241 results, all odata=100; first oidx=0, last oidx=240; one odone pulse.
REQ-026 RAM[k]=16*k, ibase=0 -> first odata=120 (avg 0..240), oidx=0; second odata=136, oidx=1.
REQ-027 Same as REQ-025 with iready=0 for cycles 20-69 -> FIFO fills to 4, reads stall, ovalid and odata held, no result lost, total still 241.
REQ-028 ibase=1020, ADDR_W=10 -> oram_addr sequence 1020,1021,1022,1023,0,1...; oma_idx 0,1,2,...
REQ-029 istart pulsed again during RUN -> ignored, frame completes normally; istart 1 cycle after odone -> new frame, CLEAR pulse seen.
REQ-030 irst=1 for 1 cycle at offset 100 -> next cycle obusy=0, ovalid=0, oram_ren=0, no odone; a subsequent istart runs a full correct frame.
